// File: rtl/regbank_sb_if.sv
// Bus bundle for regbank_sb: decode-side read/issue signals and writeback signals.
// master drives requests (decode/writeback stages); slave is the register bank.
interface regbank_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr1;
  logic [ADDR_W-1:0]     rd_addr2;
  logic [DATA_W-1:0]     rd_data1;
  logic [DATA_W-1:0]     rd_data2;
  logic                  rd_busy1;
  logic                  rd_busy2;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;
  logic                  iss_err;
  logic [ADDR_W:0]       pend_cnt;

  modport master (
    output rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, wr_be, iss_en, iss_addr,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, iss_err, pend_cnt
  );

  modport slave (
    input  rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, wr_be, iss_en, iss_addr,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, iss_err, pend_cnt
  );
endinterface

// File: rtl/regbank_sb.sv
// Byte-enable register bank with registered dual read ports, write-to-read bypass
// and a per-register pending scoreboard for issue/writeback hazard tracking.
module regbank_sb #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  regbank_sb_if.slave  bus
);
  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
  logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
  logic              rd_busy1_q, rd_busy1_d;
  logic              rd_busy2_q, rd_busy2_d;
  logic              iss_err_q, iss_err_d;
  logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;

  logic wr_ok, iss_ok, hit1, hit2;

  always_comb begin
    wr_ok  = bus.wr_en  && !((ZERO_REG != 0) && (bus.wr_addr  == '0));
    iss_ok = bus.iss_en && !((ZERO_REG != 0) && (bus.iss_addr == '0));

    regs_d = regs_q;
    if (wr_ok) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (bus.wr_be[b]) regs_d[bus.wr_addr][8*b +: 8] = bus.wr_data[8*b +: 8];
      end
    end

    // Issue wins over a same-cycle writeback: the new producer supersedes the old one.
    pend_d = pend_q;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      if (iss_ok && (bus.iss_addr == ADDR_W'(r)))
        pend_d[r] = 1'b1;
      else if (bus.wr_en && (bus.wr_addr == ADDR_W'(r)))
        pend_d[r] = 1'b0;
    end

    iss_err_d = iss_ok && pend_q[bus.iss_addr] &&
                !(bus.wr_en && (bus.wr_addr == bus.iss_addr));

    pend_cnt_d = '0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      pend_cnt_d = pend_cnt_d + CNT_W'(pend_d[r]);
    end

    hit1 = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.rd_addr1);
    hit2 = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.rd_addr2);

    rd_data1_d = rd_data1_q;
    rd_data2_d = rd_data2_q;
    rd_busy1_d = rd_busy1_q;
    rd_busy2_d = rd_busy2_q;
    if (bus.rd_en) begin
      rd_data1_d = hit1 ? regs_d[bus.rd_addr1] : regs_q[bus.rd_addr1];
      rd_busy1_d = hit1 ? pend_d[bus.rd_addr1] : pend_q[bus.rd_addr1];
      rd_data2_d = hit2 ? regs_d[bus.rd_addr2] : regs_q[bus.rd_addr2];
      rd_busy2_d = hit2 ? pend_d[bus.rd_addr2] : pend_q[bus.rd_addr2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q     <= '{default: '0};
      pend_q     <= '0;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      rd_busy1_q <= 1'b0;
      rd_busy2_q <= 1'b0;
      iss_err_q  <= 1'b0;
      pend_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      pend_q     <= pend_d;
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
      rd_busy1_q <= rd_busy1_d;
      rd_busy2_q <= rd_busy2_d;
      iss_err_q  <= iss_err_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign bus.rd_data1 = rd_data1_q;
  assign bus.rd_data2 = rd_data2_q;
  assign bus.rd_busy1 = rd_busy1_q;
  assign bus.rd_busy2 = rd_busy2_q;
  assign bus.iss_err  = iss_err_q;
  assign bus.pend_cnt = pend_cnt_q;
endmodule

// File: doc/regbank_sb.md
Name: regbank_sb

Overview:
- Parametrised multi-width register bank with byte-enable writes.
- Registered dual read ports with write-to-read bypass.
- Adds a per-register pending scoreboard for in-order issue and writeback hazard tracking.
- Sits between decode (issue/read) and writeback in the datapath; successor to the fixed 32x32 bank.

Parameters:
DATA_W, 32, register width in bits; multiple of 8
DEPTH, 32, number of registers; power of two, 2..256
ADDR_W, 5, address width; must equal log2(DEPTH)
ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes, never becomes pending
BYPASS, 1, 1 = same-cycle write data and pending-clear are forwarded to read ports

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low; must be asserted (low) at least one cycle
rd_en  in  1  read strobe; when 1, both read ports capture on this edge
rd_addr1  in  ADDR_W  read port 1 address
rd_addr2  in  ADDR_W  read port 2 address
rd_data1  out  DATA_W  registered read data, port 1
rd_data2  out  DATA_W  registered read data, port 2
rd_busy1  out  1  registered pending flag of rd_addr1
rd_busy2  out  1  registered pending flag of rd_addr2
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback address
wr_data  in  DATA_W  writeback data
wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i]
iss_en  in  1  issue strobe; marks iss_addr pending
iss_addr  in  ADDR_W  destination register of issued op
iss_err  out  1  one-cycle pulse: issue to a register still pending
pend_cnt  out  ADDR_W+1  number of pending registers

Behaviour:
- Reset (rst=0, async): all registers 0; pending vector 0; rd_data1/2=0; rd_busy1/2=0; iss_err=0; pend_cnt=0. Deassertion is synchronous to clk.
- Write: on edge with wr_en=1, bytes with wr_be[i]=1 are updated; other bytes hold. wr_be=0 writes nothing but still clears pending.
- ZERO_REG=1: writes to address 0 are discarded; read of 0 returns 0 and busy=0.
- Read latency is 1 cycle. On an edge with rd_en=1:
  - rd_dataN <= regfile[rd_addrN].
  - rd_busyN <= pending[rd_addrN].
  - When rd_en=0, rd_data/rd_busy hold their values.
- Bypass, BYPASS=1, wr_en=1 and wr_addr==rd_addrN in the same cycle:
  - rd_dataN gets the byte-merged value, i.e. the post-write contents.
  - rd_busyN gets the post-update pending bit.
- BYPASS=0: read ports capture pre-edge contents and pre-edge pending.
- Scoreboard, per register each edge:
  - set = iss_en && iss_addr==r; clr = wr_en && wr_addr==r.
  - set=1 (with or without clr) -> pending=1. Issue wins: a new producer supersedes the old one.
  - clr only -> pending=0.
  - Neither -> hold.
- ZERO_REG=1: iss_addr=0 is ignored; no set, no err.
- iss_err <= iss_en && pending[iss_addr] && !(wr_en && wr_addr==iss_addr). Otherwise 0; it is a single-cycle pulse. Pending stays 1 either way.
- pend_cnt: registered popcount of the next pending vector, valid the cycle after the update. Maximum is DEPTH (DEPTH-1 when ZERO_REG=1); no wrap.
- Reset mid-operation: all state clears immediately, including in-flight pending bits; the next issue after release behaves as from cold.
- Out-of-range addresses cannot occur, since DEPTH=2^ADDR_W.

Test Plan:
- Reset/readout: rst low, then high; rd_en=1 with addrs 3, 31 -> rd_data1=rd_data2=0, busy=0, pend_cnt=0.
- Byte-enable write: write r5=0xAABBCCDD with be=0xF, then r5=0x11223344 with be=0x5; read r5 next cycle -> 0xAA22CC44.
- Bypass: same cycle wr_en r7=0xDEADBEEF, be=0xF, rd_en, rd_addr1=7 -> next cycle rd_data1=0xDEADBEEF (BYPASS=1). With BYPASS=0, rd_data1 shows the prior value.
- Scoreboard:
  - issue r9 -> pend_cnt=1 next cycle; read r9 -> busy1=1.
  - issue r9 again with no write -> iss_err pulses exactly one cycle, pend_cnt stays 1.
  - wr r9 -> pending clears, pend_cnt=0.
- Simultaneous issue+write to r12 while pending -> r12 stays pending, iss_err=0, data updated.
- Zero reg: write r0=0xFFFFFFFF and issue r0 -> read r0=0, busy=0, pend_cnt unchanged.
- Async reset mid-run: with 4 registers pending, drop rst between edges -> outputs 0 before the next clk edge.
